// File: rtl/mem_wb_stage_if.sv
// EX/MEM-to-MEM/WB bundle: control and data from EX/MEM plus stall and registered write-back outputs.
// The misalign output exists only when MEM_MISALIGN_CHECK_EN is defined.
interface mem_wb_stage_if;
  logic [31:0] pc;
  logic [31:0] ALUresult;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        WordOrByte;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemtoReg;
  logic        RegWrite;
  logic        stall;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;

  modport master (
    output pc, ALUresult, rs2, rd, WordOrByte, MemRead, MemWrite, MemtoReg, RegWrite,
    input  stall, wb_data_out, rd_out, RegWrite_out, misalign
  );
  modport slave (
    input  pc, ALUresult, rs2, rd, WordOrByte, MemRead, MemWrite, MemtoReg, RegWrite,
    output stall, wb_data_out, rd_out, RegWrite_out, misalign
  );
`else
  modport master (
    output pc, ALUresult, rs2, rd, WordOrByte, MemRead, MemWrite, MemtoReg, RegWrite,
    input  stall, wb_data_out, rd_out, RegWrite_out
  );
  modport slave (
    input  pc, ALUresult, rs2, rd, WordOrByte, MemRead, MemWrite, MemtoReg, RegWrite,
    output stall, wb_data_out, rd_out, RegWrite_out
  );
`endif
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: synchronous data RAM, one-cycle load stall, write-back mux.
// Optional MEM_MISALIGN_CHECK_EN flags and suppresses misaligned word accesses.
module mem_wb_stage #(
  parameter int DEPTH_LOG2 = 8
) (
  input logic          clk,
  input logic          reset,
  mem_wb_stage_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             mem_q [DEPTH];
  logic [31:0]             rdata_q;
  logic [31:0]             wb_data_q, wb_data_d;
  logic [4:0]              rd_q, rd_d;
  logic                    regwrite_q, regwrite_d;
  logic                    misalign_q, misalign_d;

  logic [DEPTH_LOG2-1:0]   idx;
  logic [1:0]              lane;
  logic                    is_load, mis, wr_en, stall_c;
  logic [3:0]              be;
  logic [31:0]             wdata, ld_data;
  logic                    unused_addr;

  assign idx         = bus.ALUresult[DEPTH_LOG2+1:2];
  assign lane        = bus.ALUresult[1:0];
  assign unused_addr = ^bus.ALUresult[31:DEPTH_LOG2+2];

  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [1:0] ln,
                                           input logic wob);
    logic [7:0] b;
    b = word[8*ln +: 8];
    return wob ? word : {{24{b[7]}}, b};
  endfunction

  always_comb begin
    mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = bus.WordOrByte && (lane != 2'd0);
`endif
    is_load = bus.MemRead && !bus.MemWrite;
    // Gate with reset so stall drops the moment reset asserts, even mid-cycle.
    stall_c = reset && is_load && (state_q == IDLE);
    wr_en   = bus.MemWrite && !mis;
    be      = bus.WordOrByte ? 4'hF : (4'b0001 << lane);
    wdata   = bus.WordOrByte ? bus.rs2 : {4{bus.rs2[7:0]}};
    ld_data = (state_q == LOAD && is_load && !mis) ? load_fmt(rdata_q, lane, bus.WordOrByte)
                                                    : 32'd0;

    wb_data_d  = 32'd0;
    rd_d       = 5'd0;
    regwrite_d = 1'b0;
    if (!stall_c) begin
      unique case (bus.MemtoReg)
        2'b00:   wb_data_d = bus.ALUresult;
        2'b01:   wb_data_d = ld_data;
        2'b10:   wb_data_d = bus.pc + 32'd4;
        default: wb_data_d = 32'd0;
      endcase
      rd_d       = bus.rd;
      regwrite_d = bus.RegWrite;
    end
    misalign_d = !stall_c && mis && (bus.MemWrite || is_load);
    state_d    = (state_q == IDLE && is_load) ? LOAD : IDLE;
  end

  // Memory stage: RAM write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata_q <= mem_q[idx];
  end

  // MEM/WB boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wb_data_q  <= 32'd0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_data_q  <= wb_data_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.wb_data_out  = wb_data_q;
  assign bus.rd_out       = rd_q;
  assign bus.RegWrite_out = regwrite_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign bus.misalign     = misalign_q;
`else
  logic unused_mis;
  assign unused_mis = misalign_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed literal cases plus randomized traffic against a word-array model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage_if bus();
  mem_wb_stage #(.DEPTH_LOG2(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [256];
  bit          pend = 1'b0;
  logic [31:0] snap;
  logic [31:0] e_wb = 32'd0;
  logic [4:0]  e_rd = 5'd0;
  logic        e_rw = 1'b0;
  logic        e_mis = 1'b0;
  logic        last_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mis_m();
`ifdef MEM_MISALIGN_CHECK_EN
    return bus.WordOrByte && (bus.ALUresult[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_load_m();
    return bus.MemRead && !bus.MemWrite;
  endfunction

  task automatic model_edge();
    logic [31:0] ld;
    logic [7:0]  b;
    logic [7:0]  i;
    logic [1:0]  ln;
    bit          ms;
    i  = bus.ALUresult[9:2];
    ln = bus.ALUresult[1:0];
    ms = mis_m();
    if (!reset) begin
      e_wb = 0; e_rd = 0; e_rw = 0; e_mis = 0; pend = 0;
    end else if (is_load_m() && !pend) begin
      e_wb = 0; e_rd = 0; e_rw = 0; e_mis = 0; pend = 1;
      snap = mem_m[i];
    end else begin
      ld = 32'd0;
      if (is_load_m()) begin
        pend = 0;
        b = snap[8*ln +: 8];
        if (!ms) ld = bus.WordOrByte ? snap : {{24{b[7]}}, b};
      end
      case (bus.MemtoReg)
        2'd0: e_wb = bus.ALUresult;
        2'd1: e_wb = ld;
        2'd2: e_wb = bus.pc + 32'd4;
        default: e_wb = 32'd0;
      endcase
      e_rd  = bus.rd;
      e_rw  = bus.RegWrite;
      e_mis = ms && (bus.MemWrite || is_load_m());
      if (bus.MemWrite && !ms) begin
        if (bus.WordOrByte) mem_m[i] = bus.rs2;
        else mem_m[i][8*ln +: 8] = bus.rs2[7:0];
      end
    end
  endtask

  task automatic check_outs();
    check("wb_data_out", bus.wb_data_out, e_wb);
    check("rd_out", {27'd0, bus.rd_out}, {27'd0, e_rd});
    check("RegWrite_out", {31'd0, bus.RegWrite_out}, {31'd0, e_rw});
`ifdef MEM_MISALIGN_CHECK_EN
    check("misalign", {31'd0, bus.misalign}, {31'd0, e_mis});
`endif
  endtask

  task automatic run_cycle();
    #1;
    last_stall = bus.stall;
    check("stall", {31'd0, bus.stall}, {31'd0, reset && is_load_m() && !pend});
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic wob, input logic mr, input logic mw,
                       input logic [1:0] mtr, input logic rw);
    bus.pc = pc; bus.ALUresult = alu; bus.rs2 = rs2; bus.rd = rd; bus.WordOrByte = wob;
    bus.MemRead = mr; bus.MemWrite = mw; bus.MemtoReg = mtr; bus.RegWrite = rw;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic wob);
    drive(32'h100, addr, data, 5'd0, wob, 1'b0, 1'b1, 2'b00, 1'b0);
    run_cycle();
  endtask

  task automatic load(input logic [31:0] addr, input logic [4:0] rd, input logic wob);
    drive(32'h200, addr, 32'h0, rd, wob, 1'b1, 1'b0, 2'b01, 1'b1);
    run_cycle();
    check("load_stall_cycle", {31'd0, last_stall}, 32'd1);
    check("load_bubble", bus.wb_data_out | {27'd0, bus.rd_out} | {31'd0, bus.RegWrite_out}, 32'd0);
    run_cycle();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b1);
    #1;
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check_outs();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    reset = 1'b1;

    // ALU op after reset
    drive(0, 32'd20, 0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    run_cycle();
    check("alu_wb", bus.wb_data_out, 32'd20);
    check("alu_rd", {27'd0, bus.rd_out}, 32'd6);
    check("alu_rw", {31'd0, bus.RegWrite_out}, 32'd1);
    check("alu_stall", {31'd0, bus.stall}, 32'd0);

    for (int k = 0; k < 256; k++) store(k * 4, 32'd0, 1'b1);

    store(32'h40, 32'hDEADBEEF, 1'b1);
    load(32'h40, 5'd5, 1'b1);
    check("word_load", bus.wb_data_out, 32'hDEADBEEF);
    check("word_load_rd", {27'd0, bus.rd_out}, 32'd5);

    store(32'h40, 32'h0, 1'b1);
    store(32'h41, 32'hAAAAAA80, 1'b0);
    load(32'h40, 5'd7, 1'b1);
    check("byte_store_word", bus.wb_data_out, 32'h00008000);
    load(32'h41, 5'd8, 1'b0);
    check("byte_load_sext", bus.wb_data_out, 32'hFFFFFF80);

    // back-to-back loads alternate stall
    load(32'h40, 5'd9, 1'b1);
    load(32'h41, 5'd9, 1'b0);

    drive(32'd15, 32'h55, 0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
    run_cycle();
    check("jal_wb", bus.wb_data_out, 32'd19);
    drive(32'hFFFFFFFC, 32'h55, 0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1);
    run_cycle();
    check("jal_wrap", bus.wb_data_out, 32'd0);

    // reset asserted during the LOAD cycle
    drive(32'h300, 32'h40, 0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    run_cycle();
    #1;
    reset = 1'b0;
    #1;
    check("rst_load_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_load_wb", bus.wb_data_out, 32'd0);
    check("rst_load_rw", {31'd0, bus.RegWrite_out}, 32'd0);
    e_wb = 0; e_rd = 0; e_rw = 0; e_mis = 0; pend = 0;
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    reset = 1'b1;
    drive(0, 32'd77, 0, 5'd4, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    run_cycle();
    check("post_rst_alu", bus.wb_data_out, 32'd77);

    // reset asserted during the stall cycle drops stall immediately
    drive(32'h300, 32'h40, 0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
    #1;
    check("stall_before_rst", {31'd0, bus.stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("stall_during_rst", {31'd0, bus.stall}, 32'd0);
    pend = 0;
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
    reset = 1'b1;

`ifdef MEM_MISALIGN_CHECK_EN
    store(32'h40, 32'h11223344, 1'b1);
    store(32'h42, 32'h12345678, 1'b1);
    check("mis_store_pulse", {31'd0, bus.misalign}, 32'd1);
    load(32'h40, 5'd2, 1'b1);
    check("mis_store_kept", bus.wb_data_out, 32'h11223344);
    check("aligned_no_pulse", {31'd0, bus.misalign}, 32'd0);
    load(32'h42, 5'd2, 1'b1);
    check("mis_load_zero", bus.wb_data_out, 32'd0);
    check("mis_load_pulse", {31'd0, bus.misalign}, 32'd1);
    load(32'h43, 5'd2, 1'b0);
    check("byte_not_mis", {31'd0, bus.misalign}, 32'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      a  = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 63));
      drive($urandom, a, $urandom, 5'($urandom), 1'($urandom), op == 2 || op == 3,
            op == 1 || op == 3, 2'($urandom), 1'($urandom));
      run_cycle();
      if (op == 2) run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
